// File: rtl/i2c_master_byte.sv
// I2C master bit/byte engine: one START / STOP / WRITE / READ command at a time, open-drain SCL/SDA.
// Define I2C_STRETCH_EN to let a slave stretch SCL (quarter counter freezes while SCL is held low).
//   state   | meaning
//   IDLE    | waiting for a command, bus lines hold their last level
//   START   | four quarters generating a (repeated) start condition
//   STOP    | four quarters generating a stop condition
//   BIT     | nine bit slots of four quarters each (8 data + ack)
//   DONE    | one-cycle response, next command may be accepted
module i2c_master_byte #(
  parameter int QTR_PERIOD = 125,
  parameter int CNT_W      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd,
  input  logic [7:0] wr_data,
  input  logic       rd_nack,
  output logic       rsp_valid,
  output logic [7:0] rd_data,
  output logic       ack_nack,
  output logic       rsp_err,
  output logic       bus_owned,
  input  logic       scl_i,
  output logic       scl_oe,
  input  logic       sda_i,
  output logic       sda_oe
);

  localparam logic [1:0] CMD_START = 2'd0;
  localparam logic [1:0] CMD_STOP  = 2'd1;
  localparam logic [1:0] CMD_WRITE = 2'd2;
  localparam logic [1:0] CMD_READ  = 2'd3;
  localparam logic [CNT_W-1:0] TC  = CNT_W'(QTR_PERIOD - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_STOP, S_BIT, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [1:0]       qtr, qtr_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       bit_idx, bit_nxt;
  logic [1:0]       cmd_q, cmd_nxt;
  logic [6:0]       tx, tx_nxt;
  logic [7:0]       rx, rx_nxt;
  logic             nack_q, nack_nxt;
  logic             scl_nxt, sda_nxt, own_nxt, err_nxt, ack_nxt;
  logic [7:0]       rd_nxt;
  logic             accept, stretch, tick;

`ifdef I2C_STRETCH_EN
  // Freeze only once SCL has been released but the line is still low.
  assign stretch = !scl_i && !scl_oe &&
                   (((state == S_BIT) && (qtr == 2'd2)) ||
                    (((state == S_START) || (state == S_STOP)) && (qtr == 2'd1)));
`else
  logic scl_unused;
  assign scl_unused = scl_i;
  assign stretch    = 1'b0;
`endif

  assign cmd_ready = (state == S_IDLE) || (state == S_DONE);
  assign rsp_valid = (state == S_DONE);
  assign accept    = cmd_valid && cmd_ready;
  assign tick      = (cnt == TC) && !stretch;

  always_comb begin
    state_nxt = state;
    qtr_nxt   = qtr;
    cnt_nxt   = cnt;
    bit_nxt   = bit_idx;
    cmd_nxt   = cmd_q;
    tx_nxt    = tx;
    rx_nxt    = rx;
    nack_nxt  = nack_q;
    scl_nxt   = scl_oe;
    sda_nxt   = sda_oe;
    own_nxt   = bus_owned;
    err_nxt   = rsp_err;
    rd_nxt    = rd_data;
    ack_nxt   = ack_nack;

    if ((state == S_START) || (state == S_STOP) || (state == S_BIT)) begin
      if (!stretch) cnt_nxt = tick ? '0 : cnt + CNT_W'(1);
      if (tick) qtr_nxt = qtr + 2'd1;
    end

    case (state)
      S_IDLE, S_DONE: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
        qtr_nxt   = 2'd0;
        bit_nxt   = 4'd0;
        if (accept) begin
          cmd_nxt  = cmd;
          tx_nxt   = wr_data[6:0];
          nack_nxt = rd_nack;
          if ((cmd != CMD_START) && !bus_owned) begin
            // Rejected without touching the bus.
            state_nxt = S_DONE;
            err_nxt   = 1'b1;
          end else if (cmd == CMD_START) begin
            state_nxt = S_START;
            sda_nxt   = 1'b0;
          end else if (cmd == CMD_STOP) begin
            state_nxt = S_STOP;
            scl_nxt   = 1'b1;
            sda_nxt   = 1'b1;
          end else begin
            state_nxt = S_BIT;
            scl_nxt   = 1'b1;
            sda_nxt   = (cmd == CMD_WRITE) ? ~wr_data[7] : 1'b0;
          end
        end
      end
      S_START: begin
        if (tick) begin
          case (qtr)
            2'd0: scl_nxt = 1'b0;
            2'd1: sda_nxt = 1'b1;
            2'd2: scl_nxt = 1'b1;
            default: begin
              own_nxt   = 1'b1;
              err_nxt   = 1'b0;
              state_nxt = S_DONE;
            end
          endcase
        end
      end
      S_STOP: begin
        if (tick) begin
          case (qtr)
            2'd0: scl_nxt = 1'b0;
            2'd1: ;
            2'd2: sda_nxt = 1'b0;
            default: begin
              own_nxt   = 1'b0;
              err_nxt   = 1'b0;
              state_nxt = S_DONE;
            end
          endcase
        end
      end
      S_BIT: begin
        if ((qtr == 2'd3) && (cnt == '0)) begin
          if (bit_idx != 4'd8) rx_nxt = {rx[6:0], sda_i};
          else if (cmd_q == CMD_WRITE) ack_nxt = sda_i;
        end
        if (tick) begin
          if (qtr == 2'd1) scl_nxt = 1'b0;
          if (qtr == 2'd3) begin
            scl_nxt = 1'b1;
            if (bit_idx == 4'd8) begin
              sda_nxt   = 1'b0;
              err_nxt   = 1'b0;
              if (cmd_q == CMD_READ) rd_nxt = rx;
              state_nxt = S_DONE;
            end else begin
              bit_nxt = bit_idx + 4'd1;
              tx_nxt  = {tx[5:0], 1'b0};
              if (bit_idx == 4'd7)
                sda_nxt = (cmd_q == CMD_READ) ? ~nack_q : 1'b0;
              else
                sda_nxt = (cmd_q == CMD_WRITE) ? ~tx[6] : 1'b0;
            end
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      qtr       <= 2'd0;
      cnt       <= '0;
      bit_idx   <= 4'd0;
      cmd_q     <= CMD_START;
      tx        <= '0;
      rx        <= '0;
      nack_q    <= 1'b0;
      scl_oe    <= 1'b0;
      sda_oe    <= 1'b0;
      bus_owned <= 1'b0;
      rsp_err   <= 1'b0;
      rd_data   <= '0;
      ack_nack  <= 1'b0;
    end else begin
      state     <= state_nxt;
      qtr       <= qtr_nxt;
      cnt       <= cnt_nxt;
      bit_idx   <= bit_nxt;
      cmd_q     <= cmd_nxt;
      tx        <= tx_nxt;
      rx        <= rx_nxt;
      nack_q    <= nack_nxt;
      scl_oe    <= scl_nxt;
      sda_oe    <= sda_nxt;
      bus_owned <= own_nxt;
      rsp_err   <= err_nxt;
      rd_data   <= rd_nxt;
      ack_nack  <= ack_nxt;
    end
  end

endmodule

// File: tb/tb_i2c_master_byte.sv
// Bench for i2c_master_byte: wired-AND bus with a bit-level slave, latency and byte checks.
module tb_i2c_master_byte;
  localparam int Q        = 4;
  localparam int LAT_SS   = 4 * Q + 1;
  localparam int LAT_BYTE = 36 * Q + 1;
`ifdef I2C_STRETCH_EN
  localparam int STRETCH_EXTRA = 10;
`else
  localparam int STRETCH_EXTRA = 0;
`endif

  logic       clk = 1'b0, rst = 1'b1;
  logic       cmd_valid = 1'b0, cmd_ready;
  logic [1:0] cmd = 2'd0;
  logic [7:0] wr_data = 8'd0;
  logic       rd_nack = 1'b0;
  logic       rsp_valid, ack_nack, rsp_err, bus_owned;
  logic [7:0] rd_data;
  logic       scl_i, scl_oe, sda_i, sda_oe;

  i2c_master_byte #(.QTR_PERIOD(Q), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd),
    .wr_data(wr_data), .rd_nack(rd_nack), .rsp_valid(rsp_valid), .rd_data(rd_data),
    .ack_nack(ack_nack), .rsp_err(rsp_err), .bus_owned(bus_owned),
    .scl_i(scl_i), .scl_oe(scl_oe), .sda_i(sda_i), .sda_oe(sda_oe));

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;

  // Slave side of the wired-AND bus.
  logic       slave_sda = 1'b1, slave_hold = 1'b0;
  int         slave_mode = 0;   // 0 idle, 1 ack a write, 2 transmit a byte
  logic [7:0] slave_byte = 8'h00;
  logic       slave_ack = 1'b0;
  assign scl_i = ~scl_oe & ~slave_hold;
  assign sda_i = ~sda_oe & slave_sda;

  int         rises = 0, starts = 0, stops = 0, scl_edges = 0, sda_edges = 0;
  logic [8:0] cap = '0;
  logic       prev_scl = 1'b1, prev_sda = 1'b1;

  function automatic logic slave_bit(int r);
    case (slave_mode)
      1: return (r == 8) ? slave_ack : 1'b1;
      2: return (r < 8) ? slave_byte[7-r] : 1'b1;
      default: return 1'b1;
    endcase
  endfunction

  always @(negedge clk) begin
    if (scl_i !== prev_scl) scl_edges++;
    if (sda_i !== prev_sda) sda_edges++;
    if (prev_scl && scl_i) begin
      if (prev_sda && !sda_i) starts++;
      if (!prev_sda && sda_i) stops++;
    end
    if (!prev_scl && scl_i) begin
      if (rises < 9) cap[8-rises] = sda_i;
      rises++;
    end
    if (!scl_i) slave_sda = slave_bit(rises);
    prev_scl = scl_i;
    prev_sda = ~sda_oe & slave_sda;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called #1 after a clock edge; returns with the response visible (or budget spent).
  task automatic do_cmd(input logic [1:0] c, input logic [7:0] d, input logic nk, output int lat);
    check("cmd_ready_at_issue", cmd_ready, 1);
    cap       = '0;
    rises     = 0;
    cmd_valid = 1'b1;
    cmd       = c;
    wr_data   = d;
    rd_nack   = nk;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 2000) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  int         lat, s0, e0, rv_seen, guard;
  logic [7:0] d, exp_rd;
  logic       b, is_rd, exp_ack;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_scl_oe", scl_oe, 0);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_ack_nack", ack_nack, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_bus_owned", bus_owned, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    exp_rd = 8'h00;
    exp_ack = 1'b0;

    // Commands without bus ownership are rejected with no bus activity.
    scl_edges = 0; sda_edges = 0;
    do_cmd(2'd1, 8'h00, 1'b0, lat);
    check("err_stop_lat", lat, 1);
    check("err_stop_rsp_err", rsp_err, 1);
    do_cmd(2'd3, 8'h00, 1'b0, lat);
    check("err_read_lat", lat, 1);
    check("err_read_rsp_err", rsp_err, 1);
    check("err_read_rd_data", rd_data, exp_rd);
    do_cmd(2'd2, 8'h5A, 1'b0, lat);
    check("err_write_rsp_err", rsp_err, 1);
    repeat (4) @(posedge clk);
    #1;
    check("err_scl_quiet", scl_edges, 0);
    check("err_sda_quiet", sda_edges, 0);
    check("err_bus_owned", bus_owned, 0);

    // START from idle.
    s0 = starts;
    do_cmd(2'd0, 8'h00, 1'b0, lat);
    check("start_lat", lat, LAT_SS);
    check("start_rsp_err", rsp_err, 0);
    check("start_bus_owned", bus_owned, 1);
    check("start_condition", starts, s0 + 1);

    // WRITE 0xA5, slave ACKs (back-to-back with the START response).
    slave_mode = 1; slave_ack = 1'b0;
    do_cmd(2'd2, 8'hA5, 1'b0, lat);
    exp_ack = 1'b0;
    check("wr_a5_lat", lat, LAT_BYTE);
    check("wr_a5_bits", cap, {8'hA5, 1'b0});
    check("wr_a5_ack", ack_nack, exp_ack);
    check("wr_a5_rsp_err", rsp_err, 0);
    check("wr_a5_scl_low", scl_oe, 1);

    // READ 0x3C with NACK.
    slave_mode = 2; slave_byte = 8'h3C;
    do_cmd(2'd3, 8'h00, 1'b1, lat);
    exp_rd = 8'h3C;
    check("rd_3c_lat", lat, LAT_BYTE);
    check("rd_3c_data", rd_data, exp_rd);
    check("rd_3c_bits", cap, {8'h3C, 1'b1});
    check("rd_3c_ack_hold", ack_nack, exp_ack);

    // Random back-to-back byte transfers.
    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom_range(0, 255));
      b = 1'($urandom_range(0, 1));
      is_rd = 1'($urandom_range(0, 1));
      if (is_rd) begin
        slave_mode = 2; slave_byte = d;
        do_cmd(2'd3, ~d, b, lat);
        exp_rd = d;
      end else begin
        slave_mode = 1; slave_ack = b;
        do_cmd(2'd2, d, 1'b0, lat);
        exp_ack = b;
      end
      check("rnd_lat", lat, LAT_BYTE);
      check("rnd_bits", cap, {d, b});
      check("rnd_rd_data", rd_data, exp_rd);
      check("rnd_ack_nack", ack_nack, exp_ack);
      check("rnd_rsp_err", rsp_err, 0);
    end

    // Slave holds SCL low for 10 cycles in bit 0 q2; slave NACKs.
    slave_mode = 1; slave_ack = 1'b1; slave_hold = 1'b1;
    fork
      do_cmd(2'd2, 8'h81, 1'b0, lat);
      begin
        guard = 0;
        do begin @(posedge clk); #1; guard++; end while (scl_oe && guard < 500);
        repeat (10) @(posedge clk);
        #1 slave_hold = 1'b0;
      end
    join
    exp_ack = 1'b1;
    check("stretch_lat", lat, LAT_BYTE + STRETCH_EXTRA);
    check("stretch_ack", ack_nack, exp_ack);

    // Repeated START, then STOP.
    slave_mode = 0;
    s0 = starts;
    do_cmd(2'd0, 8'h00, 1'b0, lat);
    check("rstart_lat", lat, LAT_SS);
    check("rstart_condition", starts, s0 + 1);
    check("rstart_bus_owned", bus_owned, 1);
    s0 = stops;
    do_cmd(2'd1, 8'h00, 1'b0, lat);
    check("stop_lat", lat, LAT_SS);
    check("stop_condition", stops, s0 + 1);
    check("stop_bus_owned", bus_owned, 0);
    check("stop_rsp_err", rsp_err, 0);
    check("stop_rd_data_hold", rd_data, exp_rd);

    // Reset in the middle of a WRITE (bit 4).
    @(posedge clk); #1;
    do_cmd(2'd0, 8'h00, 1'b0, lat);
    slave_mode = 1; slave_ack = 1'b0;
    rises = 0;
    cmd_valid = 1'b1; cmd = 2'd2; wr_data = 8'hF0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    guard = 0;
    while (!(rises >= 4 && scl_oe) && guard < 500) begin @(posedge clk); #1; guard++; end
    check("midrst_reached_bit4", guard < 500, 1);
    #2 rst = 1'b1;
    #1;
    check("midrst_scl_oe", scl_oe, 0);
    check("midrst_sda_oe", sda_oe, 0);
    check("midrst_bus_owned", bus_owned, 0);
    check("midrst_cmd_ready", cmd_ready, 1);
    rv_seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (k == 3) rst = 1'b0;
      if (rsp_valid) rv_seen++;
    end
    check("midrst_no_rsp", rv_seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
